// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Purpose:
//   Shares one variable-latency memory port between the instruction-fetch
//   requester (inst_*) and the load/store requester (data_*). Only one
//   transaction is outstanding at a time. The port runs a three-state
//   handshake: IDLE -> ADDR (mem_req held until mem_addr_ok) -> DATA (wait for
//   mem_data_ok) -> IDLE. Completion is reported by a registered one-cycle ok
//   pulse, and read data is returned to the granted requester.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN - on simultaneous requests, grant the requester that
//                        was not served last. Without it, data always wins
//                        over inst, and the last-served register is absent.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   inst_req/inst_addr       fetch request and address
//   inst_rdata/inst_ok       fetched word and completion pulse
//   inst_stallreq            fetch pending, not yet completed
//   data_req/data_wen        load/store request and byte strobes (0 = load)
//   data_addr/data_wdata     load/store address and store data
//   data_rdata/data_ok       load result and completion pulse
//   data_stallreq            load/store pending, not yet completed
//   mem_req/mem_wr           downstream request and write flag
//   mem_wstrb/mem_addr       latched strobes and address
//   mem_wdata                latched store data
//   mem_addr_ok              downstream accepted the request
//   mem_data_ok/mem_rdata    downstream completion and read data
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_ok,
    output logic                  inst_stallreq,

    input  logic                  data_req,
    input  logic [DATA_W/8-1:0]   data_wen,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_ok,
    output logic                  data_stallreq,

    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    state_e              state_q;
    logic                grant_data_q;   // 1 = data requester owns the port
    logic                mem_req_q;
    logic                mem_wr_q;
    logic [STRB_W-1:0]   mem_wstrb_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   inst_rdata_q;
    logic [DATA_W-1:0]   data_rdata_q;
    logic                inst_ok_q;
    logic                data_ok_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_data_q;    // 1 = data was served last
`endif

    // A requester whose ok is pulsing this cycle is still holding req from
    // the finished transaction; it only counts as new if still high next cycle.
    logic inst_eff;
    logic data_eff;
    logic grant_data_d;

    assign inst_eff = inst_req & ~inst_ok_q;
    assign data_eff = data_req & ~data_ok_q;

    always_comb begin
        grant_data_d = data_eff;
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_eff && data_eff) begin
            grant_data_d = ~last_data_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_data_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wstrb_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q  <= 1'b0;
`endif
        end else begin
            // ok is a single-cycle pulse unless DATA completes below.
            inst_ok_q <= 1'b0;
            data_ok_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (inst_eff || data_eff) begin
                        grant_data_q <= grant_data_d;
`ifdef ARB_ROUND_ROBIN_EN
                        last_data_q  <= grant_data_d;
`endif
                        mem_req_q    <= 1'b1;
                        if (grant_data_d) begin
                            mem_addr_q  <= data_addr;
                            mem_wdata_q <= data_wdata;
                            mem_wstrb_q <= data_wen;
                            mem_wr_q    <= |data_wen;
                        end else begin
                            mem_addr_q  <= inst_addr;
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= '0;
                            mem_wr_q    <= 1'b0;
                        end
                        state_q <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (mem_addr_ok) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (mem_data_ok) begin
                        if (grant_data_q) begin
                            data_ok_q <= 1'b1;
                            // Stores leave the previous load result in place.
                            if (!mem_wr_q) begin
                                data_rdata_q <= mem_rdata;
                            end
                        end else begin
                            inst_ok_q    <= 1'b1;
                            inst_rdata_q <= mem_rdata;
                        end
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_wr        = mem_wr_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign inst_rdata    = inst_rdata_q;
    assign data_rdata    = data_rdata_q;
    assign inst_ok       = inst_ok_q;
    assign data_ok       = data_ok_q;

    assign inst_stallreq = inst_req & ~inst_ok_q;
    assign data_stallreq = data_req & ~data_ok_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed bench for sram_port_arbiter: a table of single-requester
// transactions with hand-computed expectations, followed by hand-written
// sequences for arbitration, stray responses and reset in mid-transaction.
// Follows ARB_ROUND_ROBIN_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk;
    logic                rst;
    logic                inst_req;
    logic [ADDR_W-1:0]   inst_addr;
    logic [DATA_W-1:0]   inst_rdata;
    logic                inst_ok;
    logic                inst_stallreq;
    logic                data_req;
    logic [3:0]          data_wen;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_wdata;
    logic [DATA_W-1:0]   data_rdata;
    logic                data_ok;
    logic                data_stallreq;
    logic                mem_req;
    logic                mem_wr;
    logic [3:0]          mem_wstrb;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_addr_ok;
    logic                mem_data_ok;
    logic [DATA_W-1:0]   mem_rdata;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .inst_ok       (inst_ok),
        .inst_stallreq (inst_stallreq),
        .data_req      (data_req),
        .data_wen      (data_wen),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .data_ok       (data_ok),
        .data_stallreq (data_stallreq),
        .mem_req       (mem_req),
        .mem_wr        (mem_wr),
        .mem_wstrb     (mem_wstrb),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_addr_ok   (mem_addr_ok),
        .mem_data_ok   (mem_data_ok),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_data;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;       // value returned by memory
        int          delay;       // cycles mem_addr_ok is withheld
        logic        exp_wr;
        logic [31:0] exp_wdata;   // expected on mem_wdata
        logic [31:0] exp_inst_rdata;
        logic [31:0] exp_data_rdata;
    } vec_t;

    vec_t vecs[6];

    // One single-requester transaction, starting in IDLE and ending at the
    // negedge of the cycle after the ok pulse.
    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk); #1;
        if (v.is_data) begin
            data_req = 1'b1; data_wen = v.wen; data_addr = v.addr; data_wdata = v.wdata;
        end else begin
            inst_req = 1'b1; inst_addr = v.addr;
        end
        @(negedge clk);
        chk({tag, " stall c0"}, v.is_data ? data_stallreq : inst_stallreq, 1);
        chk({tag, " mem_req c0"}, mem_req, 0);
        @(posedge clk); #1;
        for (int d = 0; d <= v.delay; d++) begin
            @(negedge clk);
            chk({tag, " mem_req"}, mem_req, 1);
            chk({tag, " mem_addr"}, mem_addr, v.addr);
            chk({tag, " mem_wr"}, mem_wr, v.exp_wr);
            chk({tag, " mem_wstrb"}, mem_wstrb, v.is_data ? v.wen : 4'b0000);
            chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
            chk({tag, " ok early"}, {inst_ok, data_ok}, 2'b00);
            chk({tag, " stall"}, v.is_data ? data_stallreq : inst_stallreq, 1);
            if (d == v.delay) mem_addr_ok = 1'b1;
            @(posedge clk); #1;
            mem_addr_ok = 1'b0;
        end
        mem_data_ok = 1'b1;
        mem_rdata   = v.rdata;
        @(negedge clk);
        chk({tag, " mem_req dropped"}, mem_req, 0);
        chk({tag, " ok in DATA"}, {inst_ok, data_ok}, 2'b00);
        @(posedge clk); #1;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        @(negedge clk);
        chk({tag, " ok pulse"}, {inst_ok, data_ok}, v.is_data ? 2'b01 : 2'b10);
        chk({tag, " inst_rdata"}, inst_rdata, v.exp_inst_rdata);
        chk({tag, " data_rdata"}, data_rdata, v.exp_data_rdata);
        chk({tag, " stall ok cycle"}, v.is_data ? data_stallreq : inst_stallreq, 0);
        inst_req = 1'b0;
        data_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " ok single"}, {inst_ok, data_ok}, 2'b00);
        chk({tag, " no new req"}, mem_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        first_data;
    logic [31:0] first_addr;
    logic [31:0] second_addr;
    vec_t        post;

    initial begin
        //             data wen    addr          wdata         rdata       dly wr  exp_wdata     inst_rdata    data_rdata
        vecs[0] = '{1'b0, 4'h0, 32'hBFC00000, 32'h00000000, 32'h3C1D0001, 0, 1'b0, 32'h00000000, 32'h3C1D0001, 32'h00000000};
        vecs[1] = '{1'b1, 4'h0, 32'h80000010, 32'h00000000, 32'hDEADBEEF, 0, 1'b0, 32'h00000000, 32'h3C1D0001, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 4'h3, 32'h80001000, 32'h1234ABCD, 32'h55555555, 0, 1'b1, 32'h1234ABCD, 32'h3C1D0001, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 4'h0, 32'hBFC00004, 32'h00000000, 32'h27BDFFF0, 5, 1'b0, 32'h00000000, 32'h27BDFFF0, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 4'hF, 32'h80002000, 32'hCAFEF00D, 32'hAAAAAAAA, 2, 1'b1, 32'hCAFEF00D, 32'h27BDFFF0, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 4'h0, 32'h80002000, 32'h00000000, 32'hCAFEF00D, 1, 1'b0, 32'h00000000, 32'h27BDFFF0, 32'hCAFEF00D};

        rst = 1'b0;
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        #12;
        chk("reset mem_req", mem_req, 0);
        chk("reset mem fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata}, 0);
        chk("reset ok", {inst_ok, data_ok}, 2'b00);
        chk("reset rdata", {inst_rdata, data_rdata}, 0);
        #10;
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Stray completion while idle.
        @(posedge clk); #1;
        mem_data_ok = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_data_ok = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk("stray ok", {inst_ok, data_ok}, 2'b00);
        chk("stray inst_rdata", inst_rdata, 32'h27BDFFF0);
        chk("stray data_rdata", data_rdata, 32'hCAFEF00D);
        chk("stray mem_req", mem_req, 0);

        // Simultaneous requests; data was served last.
`ifdef ARB_ROUND_ROBIN_EN
        first_data = 1'b0;
`else
        first_data = 1'b1;
`endif
        first_addr  = first_data ? 32'h80003000 : 32'hBFC00100;
        second_addr = first_data ? 32'hBFC00100 : 32'h80003000;
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'hBFC00100;
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h80003000; data_wdata = 32'h0;
        @(posedge clk); #1;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("sim first mem_req", mem_req, 1);
        chk("sim first mem_addr", mem_addr, first_addr);
        @(posedge clk); #1;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
        @(posedge clk); #1;
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk("sim first ok", {inst_ok, data_ok}, first_data ? 2'b01 : 2'b10);
        chk("sim loser stall", first_data ? inst_stallreq : data_stallreq, 1);
        if (first_data) data_req = 1'b0; else inst_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("sim second mem_req", mem_req, 1);
        chk("sim second mem_addr", mem_addr, second_addr);
        chk("sim no ok", {inst_ok, data_ok}, 2'b00);
        mem_addr_ok = 1'b1;
        @(posedge clk); #1;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h22222222;
        @(posedge clk); #1;
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk("sim second ok", {inst_ok, data_ok}, first_data ? 2'b10 : 2'b01);
        chk("sim inst_rdata", inst_rdata, first_data ? 32'h22222222 : 32'h11111111);
        chk("sim data_rdata", data_rdata, first_data ? 32'h11111111 : 32'h22222222);
        inst_req = 1'b0; data_req = 1'b0;

        // Reset while in DATA, then a late response after release.
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h80004000;
        @(posedge clk); #1;
        mem_addr_ok = 1'b1;
        @(posedge clk); #1;
        mem_addr_ok = 1'b0;
        @(negedge clk);
        rst = 1'b0; data_req = 1'b0;
        #1;
        chk("rst mid mem_req", mem_req, 0);
        chk("rst mid mem fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata}, 0);
        chk("rst mid rdata", {inst_rdata, data_rdata}, 0);
        chk("rst mid ok", {inst_ok, data_ok}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_data_ok = 1'b1; mem_rdata = 32'h99999999;
        @(posedge clk); #1;
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk("late resp ok", {inst_ok, data_ok}, 2'b00);
        chk("late resp rdata", data_rdata, 0);
        chk("late resp mem_req", mem_req, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("late resp ok2", {inst_ok, data_ok}, 2'b00);

        // Port is usable again from IDLE after the reset.
        post = '{1'b0, 4'h0, 32'hBFC00200, 32'h0, 32'h0BADF00D, 0, 1'b0, 32'h0, 32'h0BADF00D, 32'h0};
        run_vec(post, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares a single variable-latency memory port between the instruction-fetch requester (IF) and the load/store requester (EX/MEM).
- Grants one requester at a time and keeps only one transaction outstanding.
- Returns read data and a one-cycle completion pulse to the granted requester.
- Raises per-requester stall requests that CTRL folds into the pipeline stall bus.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports. Strobe width is DATA_W/8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset; low = in reset.
- inst_req  input  1  fetch request; held high until inst_ok.
- inst_addr  input  ADDR_W  fetch address; stable while inst_req.
- inst_rdata  output  DATA_W  fetched word; valid in the inst_ok cycle and held after it.
- inst_ok  output  1  one-cycle completion pulse.
- inst_stallreq  output  1  fetch pending, not yet completed.
- data_req  input  1  load/store request; held high until data_ok.
- data_wen  input  DATA_W/8  byte write strobes; 0 = load.
- data_addr  input  ADDR_W  load/store address.
- data_wdata  input  DATA_W  store data.
- data_rdata  output  DATA_W  load result; valid in the data_ok cycle and held after it.
- data_ok  output  1  one-cycle completion pulse (loads and stores).
- data_stallreq  output  1  load/store pending, not yet completed.
- mem_req  output  1  downstream request; held until mem_addr_ok.
- mem_wr  output  1  1 = write.
- mem_wstrb  output  DATA_W/8  latched strobes.
- mem_addr  output  ADDR_W  latched address.
- mem_wdata  output  DATA_W  latched store data.
- mem_addr_ok  input  1  downstream accepted the request.
- mem_data_ok  input  1  read data valid or write done.
- mem_rdata  input  DATA_W  downstream read data.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata = 0.
  - inst_ok, data_ok = 0.
  - inst_rdata, data_rdata = 0.
  - grant register = DATA; last-served register = INST.
- FSM states:
  - IDLE:
    - If any request is high, pick a winner.
    - Latch the winner's addr/wdata/strobes into the mem_* registers; mem_wr = |strobes (inst: strobes 0, wr 0).
    - Set mem_req = 1 and go to ADDR.
    - If no request, stay in IDLE.
  - ADDR:
    - Hold mem_req and all mem_* fields stable.
    - When mem_addr_ok = 1: clear mem_req and go to DATA.
  - DATA:
    - When mem_data_ok = 1: capture mem_rdata into the granted requester's rdata register (reads only; on writes data_rdata keeps its previous value).
    - Pulse that requester's ok for exactly 1 cycle (registered, cycle after mem_data_ok) and return to IDLE.
    - mem_addr_ok is ignored in DATA.
- Arbitration (default): fixed priority, data beats inst on simultaneous requests; inst is served on the next IDLE.
- Latency:
  - Request first seen high in cycle 0 in IDLE → mem_req high from cycle 1.
  - Best case (addr_ok in cycle 1, data_ok in cycle 2) → ok pulse in cycle 3.
  - Back-to-back transactions have one IDLE bubble.
- Stall requests (combinational):
  - inst_stallreq = inst_req & ~inst_ok.
  - data_stallreq = data_req & ~data_ok.
- Boundary conditions:
  - mem_data_ok in IDLE/ADDR: ignored, with no ok pulse (covers responses arriving after a reset).
  - A requester's req in the cycle its own ok pulses: treated as a new request only if still high in the following IDLE cycle. Requesters must drop req in the ok cycle.
  - Dropping req before ok is a protocol violation; the in-flight transaction still completes and the ok pulse is still emitted.
  - Reset mid-ADDR/DATA: abandon the transaction and clear everything, with no ok pulse.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- When defined: on simultaneous requests in IDLE, grant the requester not recorded in last-served; update last-served on every grant. Single requests are granted immediately.
- When not defined: fixed data-over-inst priority; the last-served register is absent.

Test Plan:
- Single fetch, inst_addr=0xBFC00000; addr_ok in cycle 1, data_ok in cycle 2 with mem_rdata=0x3C1D0001 → mem_addr=0xBFC00000, mem_wr=0; inst_ok high only in cycle 3; inst_rdata=0x3C1D0001; inst_stallreq high in cycles 0-2.
- Store data_wen=4'b0011, addr=0x80001000, wdata=0x1234ABCD → mem_wr=1, mem_wstrb=0011, mem_wdata=0x1234ABCD; data_ok pulse; data_rdata unchanged.
- Simultaneous inst_req and data_req in cycle 0 → data load served first; inst served from the following IDLE. Under ARB_ROUND_ROBIN_EN with last-served=DATA, inst is served first.
- mem_addr_ok delayed 5 cycles → mem_req and all mem_* fields held stable for the 5 cycles; exactly one ok pulse.
- rst driven low while in DATA, then mem_data_ok=1 after release → state IDLE, no ok pulse, all outputs 0.
- Stray mem_data_ok in IDLE with no requests → no ok pulse; rdata registers unchanged.
